cdr_bit_aligner: RTL and testbench

- Sits directly after the 5x-oversampling clock/data recovery stage in the USB2 receive path.
- Absorbs the recovery stage's one-bit-per-clock output and its ADD/DROP phase-wrap corrections in a small elastic bit buffer.
- Hunts for the SYNC pattern, then emits a steady one-bit-per-clock stream with a valid qualifier to the NRZI decoder.
- Sequences flush, prefill, hunt and active phases, and reports lock and buffer errors.

---
 rtl/cdr_bit_aligner.sv | 172 +++++++++++++++++
 tb/tb_cdr_bit_aligner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_bit_aligner.sv
// rtl/cdr_bit_aligner.sv - elastic bit buffer and SYNC hunter between the 5x CDR and the NRZI decoder
module cdr_bit_aligner #(
    parameter int          DEPTH        = 8,
    parameter logic [7:0]  SYNC_PATTERN = 8'b01010100
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     rx_enable,
    input  logic                     crd_bit,
    input  logic                     crd_add,
    input  logic                     crd_drop,
    output logic                     out_bit,
    output logic                     out_valid,
    output logic                     sync_found,
    output logic                     locked,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] C_DEPTH = (AW+2)'(DEPTH);
    localparam logic [AW+1:0] C_HALF  = (AW+2)'(DEPTH / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HUNT,
        S_ACTIVE,
        S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_buf [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_fill;
    // Only the last seven bits are kept; the eighth is the bit being read now.
    logic [6:0]      r_shreg;
    logic            r_out_bit;
    logic            r_out_valid;
    logic            r_sync_found;
    logic            r_err;

    logic            w_streaming;
    logic            w_reading;
    logic [1:0]      w_nwr;
    logic [AW+1:0]   w_fill_sum;
    logic [AW+1:0]   w_fill_next;
    logic            w_underflow;
    logic            w_overflow;
    logic            w_error;
    logic            w_rd_bit;
    logic [7:0]      w_shift;
    logic            w_match;
    logic            w_do_write;
    logic [AW-1:0]   w_wr_ptr_p1;

    assign w_streaming = rx_enable &&
                         (r_state == S_FILL || r_state == S_HUNT || r_state == S_ACTIVE);
    assign w_reading   = rx_enable && (r_state == S_HUNT || r_state == S_ACTIVE);

    always_comb begin
        w_nwr = 2'd0;
        if (w_streaming) begin
            if (crd_add && !crd_drop) begin
                w_nwr = 2'd2;
            end else if (crd_drop && !crd_add) begin
                w_nwr = 2'd0;
            end else begin
                w_nwr = 2'd1;
            end
        end
    end

    assign w_fill_sum  = {1'b0, r_fill} + (AW+2)'(w_nwr);
    assign w_fill_next = w_fill_sum - (AW+2)'(w_reading);
    assign w_underflow = w_reading && (w_fill_sum == '0);
    assign w_overflow  = !w_underflow && (w_fill_next > C_DEPTH);
    assign w_error     = w_streaming && (w_overflow || w_underflow);

    // An empty buffer forwards the bit being written this cycle.
    assign w_rd_bit    = (r_fill == '0) ? crd_bit : r_buf[r_rd_ptr];
    assign w_shift     = {r_shreg, w_rd_bit};
    assign w_match     = (w_shift == SYNC_PATTERN);
    assign w_do_write  = !w_error && (w_nwr != 2'd0);
    assign w_wr_ptr_p1 = r_wr_ptr + AW'(1);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = S_FILL;
            S_FILL: begin
                if (w_error) begin
                    w_next_state = S_ERROR;
                end else if (w_fill_next >= C_HALF) begin
                    w_next_state = S_HUNT;
                end
            end
            S_HUNT: begin
                if (w_error) begin
                    w_next_state = S_ERROR;
                end else if (w_match) begin
                    w_next_state = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_error) begin
                    w_next_state = S_ERROR;
                end
            end
            S_ERROR:  w_next_state = S_FILL;
            default:  w_next_state = S_IDLE;
        endcase
        if (!rx_enable) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_shreg      <= '0;
            r_out_bit    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_sync_found <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_sync_found <= 1'b0;
            r_err        <= w_error;
            if (!w_streaming || w_error) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_fill      <= '0;
                r_shreg     <= '0;
                r_out_bit   <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                r_wr_ptr    <= r_wr_ptr + AW'(w_nwr);
                r_rd_ptr    <= r_rd_ptr + AW'(w_reading);
                r_fill      <= w_fill_next[AW:0];
                r_out_bit   <= (r_state == S_ACTIVE) ? w_rd_bit : 1'b0;
                r_out_valid <= (r_state == S_ACTIVE);
                if (r_state == S_HUNT) begin
                    r_shreg      <= w_shift[6:0];
                    r_sync_found <= w_match;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_write) begin
            r_buf[r_wr_ptr] <= crd_bit;
            if (w_nwr == 2'd2) begin
                r_buf[w_wr_ptr_p1] <= crd_bit;
            end
        end
    end

    assign out_bit    = r_out_bit;
    assign out_valid  = r_out_valid;
    assign sync_found = r_sync_found;
    assign locked     = (r_state == S_ACTIVE);
    assign err        = r_err;
    assign fill_level = r_fill;

endmodule

// File: tb/tb_cdr_bit_aligner.sv
// tb/tb_cdr_bit_aligner.sv - self-checking bench for cdr_bit_aligner
module tb_cdr_bit_aligner;

    localparam int         DEPTH = 8;
    localparam logic [7:0] SYNC  = 8'b01010100;

    localparam int P_IDLE   = 0;
    localparam int P_FILL   = 1;
    localparam int P_HUNT   = 2;
    localparam int P_ACTIVE = 3;
    localparam int P_ERROR  = 4;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       rx_enable = 1'b0;
    logic       crd_bit   = 1'b0;
    logic       crd_add   = 1'b0;
    logic       crd_drop  = 1'b0;
    logic       out_bit;
    logic       out_valid;
    logic       sync_found;
    logic       locked;
    logic       err;
    logic [3:0] fill_level;

    cdr_bit_aligner #(.DEPTH(DEPTH), .SYNC_PATTERN(SYNC)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_enable  (rx_enable),
        .crd_bit    (crd_bit),
        .crd_add    (crd_add),
        .crd_drop   (crd_drop),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .sync_found (sync_found),
        .locked     (locked),
        .err        (err),
        .fill_level (fill_level)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: the buffer is a plain queue of bits, the hunt window the last eight bits read.
    bit         mq[$];
    logic [7:0] mwin;
    int         mph;
    bit         m_bit, m_valid, m_sf, m_err;

    typedef struct {
        bit en; bit b; bit add; bit drop;
        int fill; bit valid; bit obit; bit sf; bit lock; bit err;
    } vec_t;
    vec_t tbl[21];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic void model_flush();
        mq.delete();
        mwin    = 8'h00;
        m_bit   = 1'b0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_reset();
        model_flush();
        mph  = P_IDLE;
        m_sf = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic void model_step(bit en, bit b, bit add, bit drop);
        int n;
        bit rd;
        bit r;
        m_sf  = 1'b0;
        m_err = 1'b0;
        if (!en) begin
            model_flush();
            mph = P_IDLE;
            return;
        end
        if (mph == P_IDLE || mph == P_ERROR) begin
            mph = P_FILL;
            return;
        end
        n  = (add && !drop) ? 2 : ((drop && !add) ? 0 : 1);
        rd = (mph != P_FILL);
        if ((rd && mq.size() + n == 0) || (mq.size() + n - int'(rd) > DEPTH)) begin
            model_flush();
            mph   = P_ERROR;
            m_err = 1'b1;
            return;
        end
        repeat (n) mq.push_back(b);
        r = 1'b0;
        if (rd) r = mq.pop_front();
        case (mph)
            P_FILL: if (mq.size() >= DEPTH / 2) mph = P_HUNT;
            P_HUNT: begin
                mwin = {mwin[6:0], r};
                if (mwin == SYNC) begin
                    mph  = P_ACTIVE;
                    m_sf = 1'b1;
                end
            end
            P_ACTIVE: begin
                m_bit   = r;
                m_valid = 1'b1;
            end
            default: ;
        endcase
    endfunction

    task automatic tick(input bit en, input bit b, input bit add, input bit drop);
        rx_enable = en;
        crd_bit   = b;
        crd_add   = add;
        crd_drop  = drop;
        @(posedge clock);
        #1;
        model_step(en, b, add, drop);
        check("model_fill",   8'(fill_level), 8'(mq.size()));
        check("model_valid",  8'(out_valid),  8'(m_valid));
        check("model_bit",    8'(out_bit),    8'(m_bit));
        check("model_sync",   8'(sync_found), 8'(m_sf));
        check("model_locked", 8'(locked),     8'(mph == P_ACTIVE));
        check("model_err",    8'(err),        8'(m_err));
    endtask

    task automatic go_active();
        logic [7:0] s;
        s = SYNC;
        repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) tick(1'b1, s[i], 1'b0, 1'b0);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("go_active_locked", 8'(locked), 8'd1);
        check("go_active_fill", 8'(fill_level), 8'd4);
    endtask

    initial begin
        bit         pay[4];
        logic [7:0] s;
        logic [4:0] add_exp;
        bit         src[$];

        pay = '{1'b1, 1'b0, 1'b0, 1'b1};
        s   = SYNC;
        for (int c = 0; c < 21; c++) begin
            tbl[c].en   = 1'b1;
            tbl[c].add  = 1'b0;
            tbl[c].drop = 1'b0;
            if (c == 0)       tbl[c].b = 1'b0;
            else if (c <= 4)  tbl[c].b = 1'b1;
            else if (c <= 12) tbl[c].b = s[7 - (c - 5)];
            else if (c <= 16) tbl[c].b = pay[c - 13];
            else              tbl[c].b = 1'b1;
            tbl[c].fill  = (c < 4) ? c : 4;
            tbl[c].sf    = (c == 16);
            tbl[c].lock  = (c >= 16);
            tbl[c].valid = (c >= 17);
            tbl[c].obit  = (c >= 17) ? pay[c - 17] : 1'b0;
            tbl[c].err   = 1'b0;
        end

        model_reset();
        #3;
        check("reset_fill",   8'(fill_level), 8'd0);
        check("reset_valid",  8'(out_valid),  8'd0);
        check("reset_locked", 8'(locked),     8'd0);
        check("reset_sync",   8'(sync_found), 8'd0);
        check("reset_err",    8'(err),        8'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        for (int c = 0; c < 21; c++) begin
            tick(tbl[c].en, tbl[c].b, tbl[c].add, tbl[c].drop);
            check("tbl_fill",   8'(fill_level), 8'(tbl[c].fill));
            check("tbl_valid",  8'(out_valid),  8'(tbl[c].valid));
            check("tbl_bit",    8'(out_bit),    8'(tbl[c].obit));
            check("tbl_sync",   8'(sync_found), 8'(tbl[c].sf));
            check("tbl_locked", 8'(locked),     8'(tbl[c].lock));
            check("tbl_err",    8'(err),        8'(tbl[c].err));
        end

        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("add_fill", 8'(fill_level), 8'd5);
        check("add_err",  8'(err), 8'd0);
        add_exp = 5'b11100;
        for (int i = 4; i >= 0; i--) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            check("add_payload", 8'(out_bit), 8'(add_exp[i]));
        end

        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("drop_fill_4", 8'(fill_level), 8'd4);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("drop_fill_3", 8'(fill_level), 8'd3);
        check("drop_err", 8'(err), 8'd0);
        repeat (6) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            check("drop_payload", 8'(out_bit), 8'd1);
        end

        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("ovf_start_fill", 8'(fill_level), 8'd4);
        repeat (4) tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("ovf_full_fill", 8'(fill_level), 8'd8);
        check("ovf_full_err", 8'(err), 8'd0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("ovf_err", 8'(err), 8'd1);
        check("ovf_locked", 8'(locked), 8'd0);
        check("ovf_fill", 8'(fill_level), 8'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("ovf_err_clear", 8'(err), 8'd0);
        check("ovf_refill", 8'(fill_level), 8'd0);

        go_active();
        repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("unf_empty_fill", 8'(fill_level), 8'd0);
        check("unf_empty_err", 8'(err), 8'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        check("unf_err", 8'(err), 8'd1);
        check("unf_locked", 8'(locked), 8'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);

        go_active();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("squelch_valid", 8'(out_valid), 8'd0);
        check("squelch_fill", 8'(fill_level), 8'd0);
        check("squelch_locked", 8'(locked), 8'd0);
        repeat (14) tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("squelch_rehunt", 8'(locked), 8'd0);

        go_active();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_fill",   8'(fill_level), 8'd0);
        check("rst_mid_valid",  8'(out_valid),  8'd0);
        check("rst_mid_locked", 8'(locked),     8'd0);
        check("rst_mid_bit",    8'(out_bit),    8'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_mid_idle_fill", 8'(fill_level), 8'd0);

        for (int i = 0; i < 3000; i++) begin
            bit b;
            if (src.size() == 0) begin
                repeat (4) src.push_back(1'b1);
                for (int k = 7; k >= 0; k--) src.push_back(s[k]);
                repeat (20) src.push_back(1'($urandom_range(0, 1)));
            end
            b = src.pop_front();
            tick($urandom_range(0, 99) != 0, b,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
